// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V funct3 codes,
// fault codes and the request classifier used at acceptance time.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_ILLEGAL  = 2'b10
  } lsu_fault_t;

  // Illegal encodings win over misalignment; only the low address bits matter.
  function automatic lsu_fault_t classify(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (is_store && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    if (illegal) begin
      return FAULT_ILLEGAL;
    end
    if (misaligned) begin
      return FAULT_MISALIGN;
    end
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-data extension: sign/zero-extends right-aligned byte/half memory
// data according to the load funct3; word loads pass through.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_LH:   data = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LW:   data = raw;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RISC-V load/store unit: IDLE -> ACCESS -> RESP, faults skip ACCESS.
// Optional performance counters are built only when LSU_PERF_CNT_EN is defined.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_offset,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_write,
  output logic [2:0]      mem_type,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [1:0]      rsp_fault,
  output logic [XLEN-1:0] rsp_addr,
  output logic [31:0]     perf_loads,
  output logic [31:0]     perf_stores,
  output logic [31:0]     perf_faults
);

  lsu_state_t      state_reg, state_next;
  logic [XLEN-1:0] addr_reg, wdata_reg, rdata_reg;
  logic [2:0]      funct3_reg;
  logic            is_store_reg;
  lsu_fault_t      fault_reg;

  logic [XLEN-1:0] eff_addr;
  lsu_fault_t      req_fault;
  logic            accept;
  logic            handshake;
  logic [XLEN-1:0] ext_data;

  assign eff_addr  = req_base + req_offset;
  assign req_fault = classify(req_is_store, req_funct3, eff_addr[1:0]);
  assign accept    = req_valid && (state_reg == ST_IDLE);
  assign handshake = (state_reg == ST_RESP) && rsp_ready;

  lsu_load_extend #(.XLEN(XLEN)) u_extend (
    .funct3 (funct3_reg),
    .raw    (mem_rdata),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_addr   = '0;
    mem_write  = 1'b0;
    mem_type   = 3'b000;
    mem_wdata  = '0;
    rsp_rdata  = '0;
    rsp_fault  = 2'b00;
    rsp_addr   = '0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (req_fault == FAULT_NONE) ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        mem_addr   = addr_reg;
        mem_type   = {1'b0, funct3_reg[1:0]};
        mem_wdata  = wdata_reg;
        mem_write  = is_store_reg;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_reg;
        rsp_fault = fault_reg;
        rsp_addr  = addr_reg;
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are latched once; the load result is captured at the end of ACCESS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      funct3_reg   <= 3'b000;
      is_store_reg <= 1'b0;
      fault_reg    <= FAULT_NONE;
    end else if (accept) begin
      addr_reg     <= eff_addr;
      wdata_reg    <= req_wdata;
      rdata_reg    <= '0;
      funct3_reg   <= req_funct3;
      is_store_reg <= req_is_store;
      fault_reg    <= req_fault;
    end else if (state_reg == ST_ACCESS) begin
      rdata_reg <= is_store_reg ? '0 : ext_data;
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] loads_reg, stores_reg, faults_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loads_reg  <= '0;
      stores_reg <= '0;
      faults_reg <= '0;
    end else if (handshake) begin
      if (fault_reg != FAULT_NONE) begin
        if (faults_reg != 32'hFFFF_FFFF) faults_reg <= faults_reg + 32'd1;
      end else if (is_store_reg) begin
        if (stores_reg != 32'hFFFF_FFFF) stores_reg <= stores_reg + 32'd1;
      end else begin
        if (loads_reg != 32'hFFFF_FFFF) loads_reg <= loads_reg + 32'd1;
      end
    end
  end

  assign perf_loads  = loads_reg;
  assign perf_stores = stores_reg;
  assign perf_faults = faults_reg;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign perf_loads  = '0;
  assign perf_stores = '0;
  assign perf_faults = '0;
`endif

endmodule
